// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch PC stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HALT
  } state_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry decode buffer: flush beats write, write beats drain.
module fetch_buffer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            write,
  input  logic            drain,
  input  logic [XLEN-1:0] wr_pc,
  input  logic [XLEN-1:0] wr_inst,
  input  logic            wr_misaligned,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] inst,
  output logic            misaligned
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid      <= 1'b0;
      pc         <= '0;
      inst       <= '0;
      misaligned <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (write) begin
      valid      <= 1'b1;
      pc         <= wr_pc;
      inst       <= wr_inst;
      misaligned <= wr_misaligned;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_pc.sv
// Fetch PC stage: holds the fetch PC, issues one imem request at a time and
// hands instructions to decode through a one-entry buffer.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] io_pc_next,
  input  logic            io_redirect,
  output logic [XLEN-1:0] io_pc_pc4,
  output logic            io_imem_req_valid,
  input  logic            io_imem_req_ready,
  output logic [XLEN-1:0] io_imem_req_addr,
  input  logic            io_imem_resp_valid,
  input  logic [XLEN-1:0] io_imem_resp_data,
  output logic            io_if_valid,
  input  logic            io_if_ready,
  output logic [XLEN-1:0] io_if_pc,
  output logic [XLEN-1:0] io_if_inst,
  output logic            io_if_misaligned
);

  state_t          state, state_next;
  logic [XLEN-1:0] pc_reg, pc_nxt;
  logic            kill, kill_next;
  logic            buf_write, buf_drain, buf_free, wr_mis;
  logic [XLEN-1:0] wr_inst;

  assign buf_drain        = io_if_valid && io_if_ready;
  assign buf_free         = !io_if_valid || io_if_ready;
  assign io_pc_pc4        = pc_reg + XLEN'(4);
  assign io_imem_req_addr = pc_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_REQ;
      pc_reg <= RESET_PC;
      kill   <= 1'b0;
    end else begin
      state  <= state_next;
      pc_reg <= pc_nxt;
      kill   <= kill_next;
    end
  end

  always_comb begin
    state_next        = state;
    kill_next         = kill;
    pc_nxt            = pc_reg;
    io_imem_req_valid = 1'b0;
    buf_write         = 1'b0;
    wr_inst           = io_imem_resp_data;
    wr_mis            = 1'b0;
    if (io_redirect) begin
      pc_nxt = io_pc_next;
      case (state)
        S_HALT: state_next = S_REQ;
        S_WAIT: begin
          // A response in the redirect cycle is simply dropped; otherwise
          // remember to drop the one still in flight.
          if (io_imem_resp_valid) begin
            state_next = S_REQ;
            kill_next  = 1'b0;
          end else begin
            kill_next = 1'b1;
          end
        end
        default: ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (reset && buf_free) begin
            if (pc_reg[1:0] == 2'b00) begin
              io_imem_req_valid = 1'b1;
              if (io_imem_req_ready) state_next = S_WAIT;
            end else begin
              buf_write  = 1'b1;
              wr_inst    = XLEN'(NOP_INST);
              wr_mis     = 1'b1;
              state_next = S_HALT;
            end
          end
        end
        S_WAIT: begin
          if (io_imem_resp_valid) begin
            state_next = S_REQ;
            if (kill) begin
              kill_next = 1'b0;
            end else begin
              buf_write = 1'b1;
              pc_nxt    = io_pc_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  fetch_buffer #(.XLEN(XLEN)) u_buffer (
    .clk           (clk),
    .reset         (reset),
    .flush         (io_redirect),
    .write         (buf_write),
    .drain         (buf_drain),
    .wr_pc         (pc_reg),
    .wr_inst       (wr_inst),
    .wr_misaligned (wr_mis),
    .valid         (io_if_valid),
    .pc            (io_if_pc),
    .inst          (io_if_inst),
    .misaligned    (io_if_misaligned)
  );

endmodule

// File: tb/tb_fetch_pc.sv
// Bench for fetch_pc: directed scenarios against a transaction-level model
// plus hand-computed expectations at key cycles.
module tb_fetch_pc;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, redirect, req_ready, resp_valid, if_ready;
  logic [31:0] target, pc_next, resp_data;
  logic [31:0] pc4, req_addr, if_pc, if_inst;
  logic        req_valid, if_valid, if_mis;
  int          lat;

  logic        w_resp_valid, w_req_valid, w_if_valid, w_if_mis;
  logic [31:0] w_resp_data, w_pc_next, w_pc4, w_req_addr, w_if_pc, w_if_inst;

  int n_checks = 0;
  int n_errors = 0;

  // MuxPC stand-in: target on redirect, otherwise pc+4.
  always_comb pc_next   = redirect ? target : pc4;
  always_comb w_pc_next = w_pc4;

  fetch_pc #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .io_pc_next(pc_next), .io_redirect(redirect),
    .io_pc_pc4(pc4), .io_imem_req_valid(req_valid), .io_imem_req_ready(req_ready),
    .io_imem_req_addr(req_addr), .io_imem_resp_valid(resp_valid),
    .io_imem_resp_data(resp_data), .io_if_valid(if_valid), .io_if_ready(if_ready),
    .io_if_pc(if_pc), .io_if_inst(if_inst), .io_if_misaligned(if_mis)
  );

  fetch_pc #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .io_pc_next(w_pc_next), .io_redirect(1'b0),
    .io_pc_pc4(w_pc4), .io_imem_req_valid(w_req_valid), .io_imem_req_ready(1'b1),
    .io_imem_req_addr(w_req_addr), .io_imem_resp_valid(w_resp_valid),
    .io_imem_resp_data(w_resp_data), .io_if_valid(w_if_valid), .io_if_ready(1'b1),
    .io_if_pc(w_if_pc), .io_if_inst(w_if_inst), .io_if_misaligned(w_if_mis)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  // Memory: answers each accepted request after 'lat' cycles with mem_word(addr).
  initial begin : memory
    logic [31:0] a;
    resp_valid = 1'b0;
    resp_data  = '0;
    forever begin
      @(negedge clk);
      if (reset && req_valid && req_ready) begin
        a = req_addr;
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1;
        resp_valid = 1'b1;
        resp_data  = mem_word(a);
        @(posedge clk);
        #1;
        resp_valid = 1'b0;
      end
    end
  end

  // Model: fetch PC, an outstanding-request flag with a drop marker, a halt
  // flag and a queue of at most one deliverable entry. Checked at each
  // negedge, then advanced with the inputs that the next edge will see.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } ent_t;

  initial begin : model
    ent_t        q[$];
    ent_t        e;
    logic [31:0] m_pc;
    bit          m_out, m_drop, m_halt, m_live, free, exp_req;
    m_live = 0;
    m_pc   = '0;
    m_out  = 0;
    m_drop = 0;
    m_halt = 0;
    forever begin
      @(negedge clk);
      free    = (q.size() == 0) || if_ready;
      exp_req = reset && !redirect && !m_halt && !m_out && (m_pc[1:0] == 2'b00) && free;
      if (m_live) begin
        chk("m_req_valid", {31'd0, req_valid}, {31'd0, exp_req});
        chk("m_req_addr", req_addr, m_pc);
        chk("m_pc_pc4", pc4, m_pc + 32'd4);
        chk("m_if_valid", {31'd0, if_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
          chk("m_if_pc", if_pc, q[0].pc);
          chk("m_if_inst", if_inst, q[0].inst);
          chk("m_if_mis", {31'd0, if_mis}, {31'd0, q[0].mis});
        end
      end
      if (!reset) begin
        m_live = 1;
        m_pc   = 32'h0;
        m_out  = 0;
        m_drop = 0;
        m_halt = 0;
        q.delete();
      end else if (m_live) begin
        if (redirect) begin
          if (m_out) begin
            if (resp_valid) begin
              m_out  = 0;
              m_drop = 0;
            end else begin
              m_drop = 1;
            end
          end
          m_pc   = pc_next;
          m_halt = 0;
          q.delete();
        end else begin
          if (q.size() != 0 && if_ready) void'(q.pop_front());
          if (m_out) begin
            if (resp_valid) begin
              m_out = 0;
              if (m_drop) begin
                m_drop = 0;
              end else begin
                e.pc   = m_pc;
                e.inst = resp_data;
                e.mis  = 1'b0;
                q.push_back(e);
                m_pc = pc_next;
              end
            end
          end else if (!m_halt && free) begin
            if (m_pc[1:0] != 2'b00) begin
              e.pc   = m_pc;
              e.inst = NOP;
              e.mis  = 1'b1;
              q.push_back(e);
              m_halt = 1;
            end else if (req_ready) begin
              m_out = 1;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stim
    reset        = 1'b0;
    redirect     = 1'b0;
    target       = '0;
    req_ready    = 1'b1;
    if_ready     = 1'b1;
    lat          = 1;
    w_resp_valid = 1'b0;
    w_resp_data  = '0;

    // Reset values
    cycle(); cycle(); look();
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_if_mis", {31'd0, if_mis}, 32'd0);
    chk("rst_req_addr", req_addr, 32'd0);
    chk("rst_pc4", pc4, 32'd4);
    chk("rst_w_pc4", w_pc4, 32'd0);
    chk("rst_w_addr", w_req_addr, 32'hFFFF_FFFC);

    // Sequential fetch, 1-cycle memory
    cycle(); reset = 1'b1; look();
    chk("seq_req0_valid", {31'd0, req_valid}, 32'd1);
    chk("seq_req0_addr", req_addr, 32'h0);
    cycle(); look();
    chk("seq_wait_noreq", {31'd0, req_valid}, 32'd0);
    cycle(); look();
    chk("seq_if0_valid", {31'd0, if_valid}, 32'd1);
    chk("seq_if0_pc", if_pc, 32'h0);
    chk("seq_if0_inst", if_inst, 32'hC0DE_0000);
    chk("seq_req1_addr", req_addr, 32'h4);
    cycle(); look();
    chk("seq_gap", {31'd0, if_valid}, 32'd0);
    cycle(); look();
    chk("seq_if1_pc", if_pc, 32'h4);
    chk("seq_req2_addr", req_addr, 32'h8);

    // Decode backpressure
    cycle(); reset = 1'b0; if_ready = 1'b0;
    cycle(); cycle(); reset = 1'b1; look();
    chk("bp_req0_addr", req_addr, 32'h0);
    cycle(); look();
    cycle(); look();
    chk("bp_if0_pc", if_pc, 32'h0);
    chk("bp_noreq", {31'd0, req_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(); look();
      chk("bp_hold_valid", {31'd0, if_valid}, 32'd1);
      chk("bp_hold_pc", if_pc, 32'h0);
      chk("bp_hold_noreq", {31'd0, req_valid}, 32'd0);
    end
    cycle(); if_ready = 1'b1; look();
    chk("bp_release_req", {31'd0, req_valid}, 32'd1);
    chk("bp_release_addr", req_addr, 32'h4);
    cycle(); look();
    cycle(); look();
    chk("bp_if1_pc", if_pc, 32'h4);
    chk("bp_if1_inst", if_inst, 32'hC0DE_0004);

    // Redirect while waiting, response two cycles later
    cycle(); reset = 1'b0; lat = 3;
    cycle(); cycle(); reset = 1'b1; look();
    chk("rw_req0_addr", req_addr, 32'h0);
    cycle(); redirect = 1'b1; target = 32'h100; look();
    chk("rw_redir_noreq", {31'd0, req_valid}, 32'd0);
    cycle(); redirect = 1'b0; look();
    chk("rw_pc_target", req_addr, 32'h100);
    chk("rw_wait_noreq", {31'd0, req_valid}, 32'd0);
    cycle(); look();
    chk("rw_stale_resp", {31'd0, resp_valid}, 32'd1);
    cycle(); lat = 1; look();
    chk("rw_after_drop_valid", {31'd0, if_valid}, 32'd0);
    chk("rw_next_req", {31'd0, req_valid}, 32'd1);
    chk("rw_next_addr", req_addr, 32'h100);
    cycle(); look();
    cycle(); look();
    chk("rw_if_pc", if_pc, 32'h100);
    chk("rw_if_inst", if_inst, 32'hC0DE_0100);

    // Redirect coincident with the response
    cycle(); redirect = 1'b1; target = 32'h180; look();
    chk("co_resp_here", {31'd0, resp_valid}, 32'd1);
    cycle(); redirect = 1'b0; look();
    chk("co_dropped", {31'd0, if_valid}, 32'd0);
    chk("co_next_addr", req_addr, 32'h180);
    chk("co_next_req", {31'd0, req_valid}, 32'd1);
    cycle(); look();
    cycle(); redirect = 1'b1; target = 32'h102; look();
    chk("co_if_pc", if_pc, 32'h180);

    // Misaligned target, then resume
    cycle(); redirect = 1'b0; look();
    chk("mis_noreq", {31'd0, req_valid}, 32'd0);
    cycle(); look();
    chk("mis_valid", {31'd0, if_valid}, 32'd1);
    chk("mis_pc", if_pc, 32'h102);
    chk("mis_inst", if_inst, 32'h13);
    chk("mis_flag", {31'd0, if_mis}, 32'd1);
    chk("mis_noreq2", {31'd0, req_valid}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      cycle(); look();
      chk("halt_noreq", {31'd0, req_valid}, 32'd0);
    end
    cycle(); redirect = 1'b1; target = 32'h200; look();
    cycle(); redirect = 1'b0; look();
    chk("resume_req", {31'd0, req_valid}, 32'd1);
    chk("resume_addr", req_addr, 32'h200);
    cycle(); look();
    cycle(); look();
    chk("resume_if_pc", if_pc, 32'h200);
    chk("resume_if_mis", {31'd0, if_mis}, 32'd0);

    // Wrap-around instance
    cycle(); reset = 1'b0;
    cycle(); cycle(); reset = 1'b1; look();
    chk("wrap_req0_valid", {31'd0, w_req_valid}, 32'd1);
    chk("wrap_req0_addr", w_req_addr, 32'hFFFF_FFFC);
    chk("wrap_pc4", w_pc4, 32'h0);
    cycle(); w_resp_valid = 1'b1; w_resp_data = 32'h1234_5678; look();
    cycle(); w_resp_valid = 1'b0; look();
    chk("wrap_if_pc", w_if_pc, 32'hFFFF_FFFC);
    chk("wrap_if_inst", w_if_inst, 32'h1234_5678);
    chk("wrap_req1_valid", {31'd0, w_req_valid}, 32'd1);
    chk("wrap_req1_addr", w_req_addr, 32'h0);
    chk("wrap_pc4_next", w_pc4, 32'h4);

    cycle(); look();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
